// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester-side bus of the register-file arbiter
interface regfile_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 7
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    we;
  logic [N_REQ-1:0]    lock;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*8-1:0]  wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [7:0]          rdata;

  // requesters drive the request fields and observe grants/read data
  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  // the arbiter consumes requests and returns grants/read data
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - single-port register-file arbiter (optional write protect: REGARB_WPROTECT_EN)
module regfile_arbiter #(
  parameter int N_REQ     = 3,
  parameter int AW        = 7,
  parameter int LOCK_MAX  = 16,
  parameter int PROT_BASE = 64
) (
  input  logic              clk,
  input  logic              reset,
  regfile_arbiter_if.slave  bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              lock_abort,
  output logic              wprot_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
`ifdef REGARB_WPROTECT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef enum logic {ARB, LOCKED} state_t;

  state_t           state;
  logic [IW-1:0]    rr;
  logic [IW-1:0]    owner;
  logic [CW-1:0]    lock_cnt;
  logic [N_REQ-1:0] lock_ign;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rvalid_q;

  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] lock_ign_n;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] win_mask;
  logic [IW-1:0]    win;
  logic [AW-1:0]    win_addr;
  logic [7:0]       win_wdata;
  logic             win_we;
  logic             win_lock;
  logic             found;
  logic             cnt_max;
  logic             rel_lk;
  logic             abort_lk;
  logic             arb_mode;
  logic             prot_hit;
  int               idx;

  // Pick this edge's winner: requester 0 first, then round-robin over 1..N_REQ-1;
  // while locked only the owner may win unless the lock is being released now.
  always_comb begin
    owner_mask = N_REQ'(1) << owner;
    cnt_max    = (lock_cnt == CW'(LOCK_MAX - 1));
    rel_lk     = (state == LOCKED) && (!bus.lock[owner] || cnt_max);
    abort_lk   = (state == LOCKED) && bus.lock[owner] && cnt_max;
    lock_ign_n = (lock_ign & bus.lock) | (abort_lk ? owner_mask : '0);
    arb_mode   = (state == ARB) || rel_lk;
    elig       = bus.req & ~gnt_q & (arb_mode ? {N_REQ{1'b1}} : owner_mask);
    found      = 1'b0;
    win        = '0;
    idx        = 0;
    if (elig[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ - 1; k++) begin
        idx = 1 + ((int'(rr) - 1 + k) % (N_REQ - 1));
        if (!found && elig[idx]) begin
          found = 1'b1;
          win   = IW'(idx);
        end
      end
    end
    win_mask  = N_REQ'(1) << win;
    win_we    = bus.we[win];
    win_addr  = bus.addr[int'(win)*AW +: AW];
    win_wdata = bus.wdata[int'(win)*8 +: 8];
    win_lock  = bus.lock[win] & ~lock_ign_n[win];
    prot_hit  = WPROT && (win != '0) && win_we && (win_addr >= AW'(PROT_BASE));
  end

  // FSM plus registered grant, memory strobe and read-return pipeline.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB;
      rr         <= IW'(1);
      owner      <= '0;
      lock_cnt   <= '0;
      lock_ign   <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lock_abort <= 1'b0;
      wprot_err  <= 1'b0;
    end else begin
      rvalid_q   <= (mem_en && !mem_we) ? gnt_q : '0;
      lock_abort <= abort_lk;
      lock_ign   <= lock_ign_n;
      gnt_q      <= found ? win_mask : '0;
      mem_en     <= found && !prot_hit;
      mem_we     <= found && win_we && !prot_hit;
      wprot_err  <= found && prot_hit;
      if (found) begin
        mem_addr  <= win_addr;
        mem_wdata <= win_wdata;
      end
      if (arb_mode) begin
        state <= ARB;
        if (found && win != '0) begin
          rr <= (win == IW'(N_REQ - 1)) ? IW'(1) : win + IW'(1);
        end
        if (found && win_lock) begin
          state    <= LOCKED;
          owner    <= win;
          lock_cnt <= '0;
        end
      end else begin
        lock_cnt <= lock_cnt + CW'(1);
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = (|rvalid_q) ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - scoreboard bench for regfile_arbiter (REGARB_WPROTECT_EN aware)
module tb_regfile_arbiter;
  localparam int N_REQ     = 3;
  localparam int AW        = 7;
  localparam int LOCK_MAX  = 8;
  localparam int PROT_BASE = 64;

  typedef struct {
    int         cyc;
    int         idx;
    logic       en;
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
    logic       werr;
  } gexp_t;

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] data;
  } rexp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_en, mem_we, lock_abort, wprot_err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [7:0]    mem    [128];
  logic [7:0]    shadow [128];
  int            cyc = 0;
  int            n_assert = 0;
  int            n_fail = 0;
  gexp_t         gq[$];
  rexp_t         rq[$];
  gexp_t         ge;
  rexp_t         re;
  int            order [6] = '{0, 1, 0, 2, 0, 1};
  int            ntx [3];
  int            dn [3];
  int            c;
  bit            prot_exp;

  always #5 clk = ~clk;

  regfile_arbiter_if #(.N_REQ(N_REQ), .AW(AW)) bus ();

  regfile_arbiter #(.N_REQ(N_REQ), .AW(AW), .LOCK_MAX(LOCK_MAX), .PROT_BASE(PROT_BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .lock_abort (lock_abort),
    .wprot_err  (wprot_err)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 5) return 8'hA5;
    return 8'(i) ^ 8'h5A;
  endfunction

  function automatic logic [6:0] t3a(input int i, input int n);
    return 7'(32 + 8 * i + n);
  endfunction

  // synchronous register file: read data appears the cycle after mem_en
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic w, input logic [6:0] a, input logic [7:0] d, input logic lk);
    bus.req[i]              = 1'b1;
    bus.we[i]               = w;
    bus.addr[i*AW +: AW]    = a;
    bus.wdata[i*8 +: 8]     = d;
    bus.lock[i]             = lk;
  endtask

  task automatic expect_rd(input int cy, input int i, input logic [6:0] a);
    gexp_t g;
    rexp_t r;
    g.cyc = cy; g.idx = i; g.en = 1'b1; g.we = 1'b0; g.addr = a; g.data = 8'h00; g.werr = 1'b0;
    r.cyc = (cy < 0) ? -1 : cy + 1; r.idx = i; r.data = shadow[a];
    gq.push_back(g);
    rq.push_back(r);
  endtask

  task automatic expect_wr(input int cy, input int i, input logic [6:0] a, input logic [7:0] d, input bit prot);
    gexp_t g;
    g.cyc = cy; g.idx = i; g.en = !prot; g.we = 1'b1; g.addr = a; g.data = d; g.werr = prot;
    gq.push_back(g);
    if (!prot) shadow[a] = d;
  endtask

  // scoreboard: pop expectations as grants and read returns appear
  always @(negedge clk) begin
    if (bus.gnt !== 3'b000) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
      end else begin
        ge = gq.pop_front();
        chk("gnt_onehot", 32'(bus.gnt), 32'd1 << ge.idx);
        if (ge.cyc >= 0) chk("gnt_cycle", 32'(cyc), 32'(ge.cyc));
        chk("mem_en", 32'(mem_en), 32'(ge.en));
        chk("wprot_err", 32'(wprot_err), 32'(ge.werr));
        if (ge.en) begin
          chk("mem_we", 32'(mem_we), 32'(ge.we));
          chk("mem_addr", 32'(mem_addr), 32'(ge.addr));
          if (ge.we) chk("mem_wdata", 32'(mem_wdata), 32'(ge.data));
        end
      end
    end else begin
      chk("idle_no_strobe", 32'({mem_en, wprot_err}), 32'd0);
    end
    if (bus.rvalid !== 3'b000) begin
      if (rq.size() == 0) begin
        chk("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
      end else begin
        re = rq.pop_front();
        chk("rvalid_onehot", 32'(bus.rvalid), 32'd1 << re.idx);
        if (re.cyc >= 0) chk("rvalid_cycle", 32'(cyc), 32'(re.cyc));
        chk("rdata", 32'(bus.rdata), 32'(re.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.lock  = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < 128; i++) shadow[i] = init_val(i);
    for (int i = 0; i < 3; i++) begin ntx[i] = 0; dn[i] = 0; end
    repeat (3) tick();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_mem_en_we", 32'({mem_en, mem_we}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_abort_werr", 32'({lock_abort, wprot_err}), 32'd0);
    reset = 1'b1;
    tick();

    // single read by requester 1
    expect_rd(cyc + 1, 1, 7'h05);
    drive(1, 1'b0, 7'h05, 8'h00, 1'b0);
    tick(); bus.req[1] = 1'b0;
    tick(); tick();

    // single write by requester 2, then read it back through requester 0
    expect_wr(cyc + 1, 2, 7'h10, 8'h3C, 1'b0);
    drive(2, 1'b1, 7'h10, 8'h3C, 1'b0);
    tick(); bus.req[2] = 1'b0;
    tick(); tick();
    expect_rd(cyc + 1, 0, 7'h10);
    drive(0, 1'b0, 7'h10, 8'h00, 1'b0);
    tick(); bus.req[0] = 1'b0;
    tick(); tick();

    // all three requesting back to back: 0,1,0,2,0,1 with no idle cycle
    c = cyc;
    for (int s = 0; s < 6; s++) begin
      expect_rd(c + 1 + s, order[s], t3a(order[s], ntx[order[s]]));
      ntx[order[s]]++;
    end
    for (int i = 0; i < 3; i++) drive(i, 1'b0, t3a(i, 0), 8'h00, 1'b0);
    for (int s = 0; s < 6; s++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (bus.gnt[i]) begin
          dn[i]++;
          bus.addr[i*AW +: AW] = t3a(i, dn[i]);
        end
      end
    end
    bus.req = '0;
    tick(); tick();

    // locked three-byte read by requester 1 holds off requester 0
    c = cyc;
    expect_rd(c + 1, 1, 7'h40);
    expect_rd(c + 3, 1, 7'h41);
    expect_rd(c + 5, 1, 7'h42);
    expect_rd(c + 6, 0, 7'h30);
    drive(1, 1'b0, 7'h40, 8'h00, 1'b1);
    tick();
    drive(0, 1'b0, 7'h30, 8'h00, 1'b0);
    bus.addr[AW +: AW] = 7'h41;
    tick(); tick();
    bus.addr[AW +: AW] = 7'h42;
    tick(); tick();
    bus.req[1] = 1'b0; bus.lock[1] = 1'b0;
    tick();
    bus.req[0] = 1'b0;
    tick(); tick();

    // lock held forever: forced release after LOCK_MAX cycles, lock then ignored
    c = cyc;
    expect_rd(c + 1, 1, 7'h44);
    expect_rd(-1, 0, 7'h31);
    drive(1, 1'b0, 7'h44, 8'h00, 1'b1);
    tick();
    bus.req[1] = 1'b0;
    drive(0, 1'b0, 7'h31, 8'h00, 1'b0);
    for (int k = 2; k <= 8; k++) tick();
    chk("lock_abort_early", 32'(lock_abort), 32'd0);
    tick();
    chk("lock_abort_pulse", 32'(lock_abort), 32'd1);
    bus.req[0] = 1'b0;
    expect_rd(c + 10, 1, 7'h45);
    drive(1, 1'b0, 7'h45, 8'h00, 1'b1);
    tick();
    chk("lock_abort_single", 32'(lock_abort), 32'd0);
    bus.req[1] = 1'b0;
    expect_rd(c + 11, 0, 7'h32);
    drive(0, 1'b0, 7'h32, 8'h00, 1'b0);
    tick();
    bus.req[0] = 1'b0; bus.lock[1] = 1'b0;
    tick(); tick();
    chk("lock_release_drained", 32'(gq.size()), 32'd0);

    // protected-range writes
`ifdef REGARB_WPROTECT_EN
    prot_exp = 1'b1;
`else
    prot_exp = 1'b0;
`endif
    expect_wr(cyc + 1, 1, 7'h40, 8'h77, prot_exp);
    drive(1, 1'b1, 7'h40, 8'h77, 1'b0);
    tick(); bus.req[1] = 1'b0;
    tick();
    expect_rd(cyc + 1, 2, 7'h40);
    drive(2, 1'b0, 7'h40, 8'h00, 1'b0);
    tick(); bus.req[2] = 1'b0;
    tick();
    expect_wr(cyc + 1, 0, 7'h40, 8'h88, 1'b0);
    drive(0, 1'b1, 7'h40, 8'h88, 1'b0);
    tick(); bus.req[0] = 1'b0;
    tick();
    expect_rd(cyc + 1, 2, 7'h40);
    drive(2, 1'b0, 7'h40, 8'h00, 1'b0);
    tick(); bus.req[2] = 1'b0;
    tick(); tick();

    // reset between grant and read return drops the read
    ge.cyc = cyc + 1; ge.idx = 0; ge.en = 1'b1; ge.we = 1'b0; ge.addr = 7'h41; ge.data = 8'h00; ge.werr = 1'b0;
    gq.push_back(ge);
    drive(0, 1'b0, 7'h41, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    bus.req = '0;
    tick();
    chk("reset_drops_rvalid", 32'(bus.rvalid), 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick();

    chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
    chk("rd_queue_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
